mem_bank_resp: RTL and testbench

Main-memory responder for the cache controller's memory side: four-way word-interleaved banked memory.
- Accepts single-word read/write requests.
- Tracks per-bank busy time and flags conflicts with a stall.
- Returns read data at a fixed latency.
- Sits directly below the cache FSM, which drives the word offset 0,2,4,6 to touch banks 0..3 back-to-back.

---
 rtl/mem_bank_pkg.sv | 32 +++
 rtl/mem_bank.sv | 57 +++++
 rtl/mem_bank_resp.sv | 130 +++++++++++++
 tb/tb_mem_bank_resp.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// mem_bank_pkg: shared constants, types and helpers for the four-way
// word-interleaved banked memory responder (mem_bank_resp).
//
// Contents:
//   N_BANKS, BANK_BUSY, RD_LAT   - bank count, occupancy and read latency
//   BANK_LSB, BANK_W, ROW_LSB    - address field positions
//   CNT_W                        - width of the per-bank busy counter
//   req_kind_e                   - decoded request kind
//   row_w()                      - row index width for a given bank depth
package mem_bank_pkg;

    localparam int N_BANKS   = 4;
    localparam int BANK_BUSY = 4;
    localparam int RD_LAT    = 2;

    localparam int BANK_LSB  = 1;
    localparam int BANK_W    = 2;
    localparam int ROW_LSB   = 3;

    localparam int CNT_W     = 2;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_READ,
        REQ_WRITE
    } req_kind_e;

    function automatic int row_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// mem_bank: one bank of the interleaved memory.
//
// Holds the bank's word storage and its occupancy counter. An accepted
// request loads the counter with BANK_BUSY-1, and the bank reports busy
// while the counter is non-zero.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (counter only)
//   accept    - a request to this bank is accepted this cycle
//   we        - accepted request is a write
//   wr_row    - row written on we
//   wr_data   - write data
//   rd_row    - row read combinationally onto rd_data
//   rd_data   - word stored at rd_row
//   busy      - bank occupied, cannot accept
module mem_bank
    import mem_bank_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ROW_W  = row_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              we,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(BANK_BUSY - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy    = (cnt != '0);
    assign rd_data = mem[rd_row];

endmodule

// File: rtl/mem_bank_resp.sv
// mem_bank_resp: main-memory responder below the cache controller.
//
// Four word-interleaved banks (bank = addr[2:1], row = addr[3 +: row_w]).
// Single-word reads and writes are accepted when the target bank is idle;
// a busy bank raises stall and the requester holds the request. Reads
// return data_out with a one-cycle rd_valid pulse RD_LAT cycles after
// acceptance. Odd byte addresses are rejected with err.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   addr      - byte address
//   data_in   - write data
//   wr, rd    - write / read request
//   data_out  - read data, zero unless rd_valid
//   rd_valid  - read data pulse
//   stall     - request not accepted, target bank busy
//   busy      - per-bank busy flags
//   err       - request rejected as illegal
//
// Build option MEM_STRICT_ERR_EN: when defined, rd&wr together and row
// fields at or beyond DEPTH are also rejected with err. When undefined,
// rd&wr acts as a write and upper address bits alias onto the rows.
module mem_bank_resp
    import mem_bank_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                wr,
    input  logic                rd,
    output logic [DATA_W-1:0]   data_out,
    output logic                rd_valid,
    output logic                stall,
    output logic [N_BANKS-1:0]  busy,
    output logic                err
);

    localparam int ROW_W = row_w(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [BANK_W-1:0] bank;
        logic [ROW_W-1:0]  row;
    } rd_pipe_t;

    logic              req;
    logic              illegal;
    logic              accept;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    req_kind_e         kind;
    rd_pipe_t          pipe [RD_LAT];
    logic [DATA_W-1:0] bank_rdata [N_BANKS];
    logic              unused_addr_bits;

    assign req  = rd | wr;
    assign bank = addr[BANK_LSB +: BANK_W];
    assign row  = addr[ROW_LSB +: ROW_W];

    // A simultaneous rd & wr decodes as a write; in the strict build it is
    // rejected before it can be accepted.
    always_comb begin
        kind = REQ_NONE;
        if (wr) begin
            kind = REQ_WRITE;
        end else if (rd) begin
            kind = REQ_READ;
        end
    end

`ifdef MEM_STRICT_ERR_EN
    assign illegal = addr[0] | (rd & wr) |
                     (addr[ADDR_W-1:ROW_LSB] >= (ADDR_W-ROW_LSB)'(DEPTH));
`else
    assign illegal = addr[0];
`endif

    // Bits above the row field only matter for the strict range check.
    assign unused_addr_bits = ^addr[ADDR_W-1:ROW_LSB+ROW_W];

    assign err    = req & illegal;
    assign stall  = req & busy[bank] & ~err;
    assign accept = req & ~busy[bank] & ~err;

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        logic sel;
        assign sel = accept && (bank == BANK_W'(g));

        mem_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .accept  (sel),
            .we      (sel && (kind == REQ_WRITE)),
            .wr_row  (row),
            .wr_data (data_in),
            .rd_row  (pipe[RD_LAT-1].row),
            .rd_data (bank_rdata[g]),
            .busy    (busy[g])
        );
    end

    // Bank and row of each accepted read travel with its valid bit. The bank
    // stays busy beyond RD_LAT, so the array read at the pipe tail cannot be
    // overtaken by a later write to the same bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: accept && (kind == REQ_READ), bank: bank, row: row};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rd_valid = pipe[RD_LAT-1].valid;
    assign data_out = rd_valid ? bank_rdata[pipe[RD_LAT-1].bank] : '0;

endmodule

// File: tb/tb_mem_bank_resp.sv
// tb_mem_bank_resp: scoreboard bench for mem_bank_resp.
//
// The stimulus process drives directed requests, checks stall/err/busy in
// the same cycle, and pushes the expected read data and return cycle of
// each accepted read into a queue. A separate monitor pops that queue on
// every rd_valid and compares cycle and data, and checks data_out is zero
// otherwise. Honours MEM_STRICT_ERR_EN in the same way as the design.
module tb_mem_bank_resp;
    import mem_bank_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 64;

`ifdef MEM_STRICT_ERR_EN
    localparam logic        STRICT = 1'b1;
`else
    localparam logic        STRICT = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              stall;
    logic [3:0]        busy;
    logic              err;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    mem_bank_resp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wr       (wr),
        .rd       (rd),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .stall    (stall),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h",
                     name, cyc, actual, expected);
        end
    endtask

    // Drives one request for one cycle, checks the same-cycle outputs, and
    // queues the read response if the request is expected to be accepted.
    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [15:0] a, input logic [15:0] d,
                                 input logic exp_stall, input logic exp_err,
                                 input logic [3:0] exp_busy,
                                 input logic exp_rd, input logic [15:0] exp_data);
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        @(negedge clk);
        checkOutput("stall", 32'(stall), 32'(exp_stall));
        checkOutput("err", 32'(err), 32'(exp_err));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        if (exp_rd) begin
            sb.push_back('{cyc + RD_LAT, exp_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] exp_busy);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, exp_busy, 1'b0, 16'h0000);
    endtask

    // Monitor: every rd_valid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("[TB] FAIL rd_unexpected at cycle %0d: actual rd_valid=1 data=%0h required rd_valid=0",
                         cyc, data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rd_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("rd_data", 32'(data_out), 32'(e.data));
            end
        end else begin
            checkOutput("data_out_idle", 32'(data_out), 32'h0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        logic [15:0] exp_rw_data;
        logic [3:0]  rw_busy;
        exp_rw_data = STRICT ? 16'h0001 : 16'h5555;
        rw_busy     = STRICT ? 4'b0000 : 4'b0001;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("reset_data_out", 32'(data_out), 32'h0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] write then read after bank free");
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0);
        idle(4'b0001); idle(4'b0001); idle(4'b0001);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'hBEEF);
        idle(4'b0001); idle(4'b0001); idle(4'b0001); idle(4'b0000);

        $display("[TB] same-bank conflict stalls");
        applyStimulus(1'b0, 1'b1, 16'h0018, 16'h1234, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0);
        idle(4'b0001); idle(4'b0001); idle(4'b0001);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0018, 16'h0000, 1'b1, 1'b0, 4'b0001, 1'b0, 16'h0);
        end
        applyStimulus(1'b1, 1'b0, 16'h0018, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h1234);
        idle(4'b0001); idle(4'b0001); idle(4'b0001); idle(4'b0000);

        $display("[TB] interleaved writes and back-to-back reads");
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 4'b0001, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0004, 16'h0003, 1'b0, 1'b0, 4'b0011, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h0006, 16'h0004, 1'b0, 1'b0, 4'b0111, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b1110, 1'b1, 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 4'b1101, 1'b1, 16'h0002);
        applyStimulus(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 4'b1011, 1'b1, 16'h0003);
        applyStimulus(1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b0, 4'b0111, 1'b1, 16'h0004);
        idle(4'b1110); idle(4'b1100); idle(4'b1000); idle(4'b0000);

        $display("[TB] odd address rejected, err over stall");
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, 16'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b1, 4'b0001, 1'b0, 16'h0);
        idle(4'b0001); idle(4'b0001); idle(4'b0000);
        applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h0);
        idle(4'b0000);

        $display("[TB] reset discards in-flight read");
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h0);
        rd  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post_rst_rd_valid", 32'(rd_valid), 32'h0);
            checkOutput("post_rst_busy", 32'(busy), 32'h0);
            @(posedge clk);
            #1;
        end

        $display("[TB] rd and wr together, out-of-range row");
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h5555, 1'b0, STRICT, 4'b0000, 1'b0, 16'h0);
        idle(rw_busy); idle(rw_busy); idle(rw_busy);
        applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1, exp_rw_data);
        idle(4'b0001); idle(4'b0001); idle(4'b0001);
        applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, STRICT, 4'b0000, !STRICT, 16'h5555);
        idle(rw_busy); idle(rw_busy); idle(rw_busy); idle(4'b0000);

        idle(4'b0000); idle(4'b0000);
        checkOutput("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
